// File: rtl/alu_secuenciador.sv
// Issue/writeback sequencer around a combinational ALU: a small register bank, a valid/ready command port and result writeback.
// Optional conditional execution is compiled in with `define ALU_SECUENCIADOR_COND_EN.
module alu_secuenciador #(
  parameter  int DATA_W = 4,
  parameter  int OP_W   = 4,
  parameter  int NREG   = 4,
  localparam int SEL_W  = $clog2(NREG)
) (
  input  logic              iClk,
  input  logic              iReset,
`ifdef ALU_SECUENCIADOR_COND_EN
  input  logic [1:0]        ivCondicion,
  output logic              oOmitido,
`endif
  input  logic              iValido,
  output logic              oListo,
  input  logic [OP_W-1:0]   ivInstruccion,
  input  logic [SEL_W-1:0]  ivSelA,
  input  logic [SEL_W-1:0]  ivSelB,
  input  logic [SEL_W-1:0]  ivSelDestino,
  input  logic              iCargar,
  input  logic [SEL_W-1:0]  ivSelCarga,
  input  logic [DATA_W-1:0] ivDatoCarga,
  input  logic [SEL_W-1:0]  ivSelLectura,
  output logic [DATA_W-1:0] ovDatoLectura,
  output logic [OP_W-1:0]   ovAluInstruccion,
  output logic [DATA_W-1:0] ovAluA,
  output logic [DATA_W-1:0] ovAluB,
  input  logic [DATA_W-1:0] ivAluResultado,
  input  logic [3:0]        ivAluFlags,
  output logic [3:0]        ovFlags,
  output logic              oHecho
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  logic [0:0]        r_estado;
  logic [DATA_W-1:0] r_banco [NREG];
  logic [SEL_W-1:0]  r_dest;
  logic [3:0]        r_flags;
  logic              r_hecho;
  logic              r_ejecutar;
  logic [OP_W-1:0]   r_alu_instr;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              w_cond_ok;
  logic              w_escribe;

`ifdef ALU_SECUENCIADOR_COND_EN
  logic              r_omitido;

  // Condition is judged against the flags as they stand at acceptance
  always_comb begin
    w_cond_ok = 1'b1;
    case (ivCondicion)
      2'b00:   w_cond_ok = 1'b1;
      2'b01:   w_cond_ok = r_flags[0];
      2'b10:   w_cond_ok = r_flags[1];
      2'b11:   w_cond_ok = ~r_flags[0];
      default: w_cond_ok = 1'b1;
    endcase
  end

  assign oOmitido = r_omitido;
`else
  assign w_cond_ok = 1'b1;
`endif

  assign oListo           = (r_estado == ST_IDLE) && !iReset;
  assign w_escribe        = (r_estado == ST_EXEC) && r_ejecutar;
  assign ovDatoLectura    = r_banco[ivSelLectura];
  assign ovAluInstruccion = r_alu_instr;
  assign ovAluA           = r_alu_a;
  assign ovAluB           = r_alu_b;
  assign ovFlags          = r_flags;
  assign oHecho           = r_hecho;

  // Register bank: writeback is assigned last so it wins a same-register collision with a load
  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int i = 0; i < NREG; i++) begin
        r_banco[i] <= '0;
      end
    end else begin
      if (iCargar) begin
        r_banco[ivSelCarga] <= ivDatoCarga;
      end
      if (w_escribe) begin
        r_banco[r_dest] <= ivAluResultado;
      end
    end
  end

  // Sequencing FSM: capture operands on acceptance, retire the ALU result one cycle later
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_estado    <= ST_IDLE;
      r_dest      <= '0;
      r_flags     <= 4'b0000;
      r_hecho     <= 1'b0;
      r_ejecutar  <= 1'b0;
      r_alu_instr <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
`ifdef ALU_SECUENCIADOR_COND_EN
      r_omitido   <= 1'b0;
`endif
    end else begin
      r_hecho <= 1'b0;
`ifdef ALU_SECUENCIADOR_COND_EN
      r_omitido <= 1'b0;
`endif
      case (r_estado)
        ST_IDLE: begin
          if (iValido) begin
            r_alu_instr <= ivInstruccion;
            r_alu_a     <= r_banco[ivSelA];
            r_alu_b     <= r_banco[ivSelB];
            r_dest      <= ivSelDestino;
            r_ejecutar  <= w_cond_ok;
            r_estado    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_ejecutar) begin
            r_flags <= ivAluFlags;
          end
          r_hecho  <= 1'b1;
`ifdef ALU_SECUENCIADOR_COND_EN
          r_omitido <= ~r_ejecutar;
`endif
          r_estado <= ST_IDLE;
        end
        default: r_estado <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuenciador.sv
// Scoreboard bench for alu_secuenciador: a behavioural 4-bit ALU closes the loop,
// a per-edge bank model predicts results, and a negedge monitor checks them.
module tb_alu_secuenciador;

  logic       iClk;
  logic       iReset;
  logic       iValido;
  logic       oListo;
  logic [3:0] ivInstruccion;
  logic [1:0] ivSelA, ivSelB, ivSelDestino;
  logic       iCargar;
  logic [1:0] ivSelCarga;
  logic [3:0] ivDatoCarga;
  logic [1:0] ivSelLectura;
  logic [3:0] ovDatoLectura;
  logic [3:0] ovAluInstruccion, ovAluA, ovAluB;
  logic [3:0] ivAluResultado, ivAluFlags;
  logic [3:0] ovFlags;
  logic       oHecho;
  logic [1:0] cond_s;
`ifdef ALU_SECUENCIADOR_COND_EN
  logic       oOmitido;
`endif

  typedef struct {
    logic [3:0] op, a, b, res, fl;
    logic [1:0] dest;
    logic       skip;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       m_cur;
  exp_t       mon_e;
  logic [3:0] m_bank [4];
  logic [3:0] m_flags;
  logic       m_busy;
  int         total = 0;
  int         bad   = 0;

  alu_secuenciador dut (
    .iClk(iClk), .iReset(iReset),
`ifdef ALU_SECUENCIADOR_COND_EN
    .ivCondicion(cond_s), .oOmitido(oOmitido),
`endif
    .iValido(iValido), .oListo(oListo), .ivInstruccion(ivInstruccion),
    .ivSelA(ivSelA), .ivSelB(ivSelB), .ivSelDestino(ivSelDestino),
    .iCargar(iCargar), .ivSelCarga(ivSelCarga), .ivDatoCarga(ivDatoCarga),
    .ivSelLectura(ivSelLectura), .ovDatoLectura(ovDatoLectura),
    .ovAluInstruccion(ovAluInstruccion), .ovAluA(ovAluA), .ovAluB(ovAluB),
    .ivAluResultado(ivAluResultado), .ivAluFlags(ivAluFlags),
    .ovFlags(ovFlags), .oHecho(oHecho)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference ALU: returns {V,N,C,Z,result}
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] w;
    logic       v;
    w = 5'd0;
    v = 1'b0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; v = (a[3] == b[3]) && (w[3] != a[3]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; v = (a[3] != b[3]) && (w[3] != a[3]); end
      4'd2: w = {1'b0, a & b};
      4'd3: w = {1'b0, a | b};
      4'd4: w = {1'b0, a ^ b};
      default: w = {1'b0, a};
    endcase
    return {v, w[3], w[4], (w[3:0] == 4'd0), w[3:0]};
  endfunction

  function automatic logic cond_ok(input logic [1:0] c, input logic [3:0] f);
    case (c)
      2'b01:   return f[0];
      2'b10:   return f[1];
      2'b11:   return !f[0];
      default: return 1'b1;
    endcase
  endfunction

  assign {ivAluFlags, ivAluResultado} = alu_ref(ovAluInstruccion, ovAluA, ovAluB);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge: drive inputs, advance the model by the same edge, check ready
  task automatic step(input logic v, input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [1:0] sd, input logic [1:0] cond, input logic cg,
                      input logic [1:0] sc, input logic [3:0] dc, input logic rst);
    exp_t e;
    logic acc;
    iValido = v; ivInstruccion = op; ivSelA = sa; ivSelB = sb; ivSelDestino = sd;
    cond_s = cond; iCargar = cg; ivSelCarga = sc; ivDatoCarga = dc; iReset = rst;
    @(posedge iClk);
    acc = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_bank[i] = 4'd0;
      m_flags = 4'd0;
      m_busy  = 1'b0;
      exp_q.delete();
    end else begin
      if (!m_busy && v) begin
        e.op = op; e.a = m_bank[sa]; e.b = m_bank[sb]; e.dest = sd;
        {e.fl, e.res} = alu_ref(op, e.a, e.b);
        e.skip = !cond_ok(cond, m_flags);
        exp_q.push_back(e);
        acc = 1'b1;
      end
      if (cg) m_bank[sc] = dc;
      if (m_busy) begin
        if (!m_cur.skip) begin
          m_bank[m_cur.dest] = m_cur.res;
          m_flags = m_cur.fl;
        end
        m_busy = 1'b0;
      end else if (acc) begin
        m_cur  = e;
        m_busy = 1'b1;
      end
    end
    #1;
    if (acc) ivSelLectura = sd;
    chk("listo", {7'd0, oListo}, {7'd0, !rst && !m_busy});
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic load(input logic [1:0] sc, input logic [3:0] dc);
    step(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, sc, dc, 1'b0);
  endtask

  task automatic read_chk(input string nm, input logic [1:0] sel, input logic [3:0] exp);
    ivSelLectura = sel;
    #1;
    chk(nm, {4'd0, ovDatoLectura}, {4'd0, exp});
  endtask

  // Monitor: operand check in EXEC, result/flags check on the completion pulse
  always @(negedge iClk) begin
    if (!iReset) begin
      if (!oListo) begin
        if (exp_q.size() == 0) begin
          chk("exec_unexpected", 8'd1, 8'd0);
        end else begin
          chk("alu_instr", {4'd0, ovAluInstruccion}, {4'd0, exp_q[0].op});
          chk("alu_a", {4'd0, ovAluA}, {4'd0, exp_q[0].a});
          chk("alu_b", {4'd0, ovAluB}, {4'd0, exp_q[0].b});
        end
      end
      if (oHecho) begin
        if (exp_q.size() == 0) begin
          chk("hecho_unexpected", 8'd1, 8'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_data", {4'd0, ovDatoLectura}, {4'd0, mon_e.skip ? m_bank[mon_e.dest] : mon_e.res});
          chk("wb_flags", {4'd0, ovFlags}, {4'd0, mon_e.skip ? m_flags : mon_e.fl});
`ifdef ALU_SECUENCIADOR_COND_EN
          chk("omitido", {7'd0, oOmitido}, {7'd0, mon_e.skip});
`endif
        end
      end
    end
  end

  initial begin
    ivSelLectura = 2'd0;
    m_busy = 1'b0;
    m_flags = 4'd0;
    for (int i = 0; i < 4; i++) m_bank[i] = 4'd0;

    step(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 4'd5, 1'b1);
    step(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
    iReset = 1'b0;
    #1;
    chk("rst_listo", {7'd0, oListo}, 8'd1);
    chk("rst_hecho", {7'd0, oHecho}, 8'd0);
    chk("rst_flags", {4'd0, ovFlags}, 8'd0);
    chk("rst_alu", {ovAluA, ovAluB}, 8'd0);
    for (int i = 0; i < 4; i++) read_chk("rst_bank", 2'(i), 4'd0);

    // Reset during EXEC aborts the command
    load(2'd3, 4'd7);
    step(1'b1, 4'd0, 2'd3, 2'd3, 2'd1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
    iReset = 1'b0;
    #1;
    chk("abort_listo", {7'd0, oListo}, 8'd1);
    read_chk("abort_dest", 2'd1, 4'd0);
    idle();
    idle();

    // Basic add and writeback/load collision
    load(2'd0, 4'd1);
    load(2'd1, 4'd1);
    step(1'b1, 4'd0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 4'hF, 1'b0);
    idle();
    read_chk("collide_same", 2'd2, 4'h2);
    step(1'b1, 4'd0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd3, 4'hF, 1'b0);
    idle();
    read_chk("collide_other", 2'd3, 4'hF);
    read_chk("collide_keep", 2'd2, 4'h2);

    // Back-to-back dependency with iValido held high
    load(2'd0, 4'd3);
    step(1'b1, 4'd0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b1, 4'd0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b1, 4'd0, 2'd2, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
    chk("b2b_operand", {4'd0, ovAluA}, 8'd6);
    idle();
    idle();
    read_chk("b2b_result", 2'd1, 4'd9);
    chk("b2b_flags", {4'd0, ovFlags}, 8'hC);

`ifdef ALU_SECUENCIADOR_COND_EN
    step(1'b1, 4'd0, 2'd0, 2'd0, 2'd3, 2'b01, 1'b0, 2'd0, 4'd0, 1'b0);
    idle();
    idle();
    read_chk("cond_dest", 2'd3, 4'hF);
    chk("cond_flags", {4'd0, ovFlags}, 8'hC);
`endif

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
`ifdef ALU_SECUENCIADOR_COND_EN
           2'($urandom_range(0, 3)),
`else
           2'd0,
`endif
           ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) == 0));
    end
    idle();
    idle();
    idle();
    chk("queue_drain", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_secuenciador.md
Name: alu_secuenciador

Overview:
- Issue/writeback stage directly upstream of the 4-bit ALU.
- Holds a small register bank and accepts operation commands over a valid/ready handshake.
- Drives the ALU's instruction and operand inputs from registered values, then writes the ALU result back into the bank and latches the flags.
- The ALU itself stays combinational; this block supplies all sequencing around it.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU.
- OP_W, 4, instruction width.
- NREG, 4, register bank depth; power of 2, at least 2. SEL_W = log2(NREG).

Ports:
- iClk  in  1  sole clock; rising edge.
- iReset  in  1  synchronous, active-high reset.
- iValido  in  1  command valid.
- oListo  out  1  command ready.
- ivInstruccion  in  OP_W  opcode, forwarded unchanged to the ALU.
- ivSelA  in  SEL_W  source register for operand A.
- ivSelB  in  SEL_W  source register for operand B.
- ivSelDestino  in  SEL_W  destination register.
- iCargar  in  1  direct register load strobe.
- ivSelCarga  in  SEL_W  load target register.
- ivDatoCarga  in  DATA_W  load data.
- ivSelLectura  in  SEL_W  readback select.
- ovDatoLectura  out  DATA_W  combinational readback of bank[ivSelLectura].
- ovAluInstruccion  out  OP_W  to ALU ivInstruccion.
- ovAluA  out  DATA_W  to ALU ivRegistroA.
- ovAluB  out  DATA_W  to ALU ivRegistroB.
- ivAluResultado  in  DATA_W  from ALU ovResultado.
- ivAluFlags  in  4  from ALU ovFlags; bit0 Zero, bit1 Carry, bit2 Negative, bit3 Overflow.
- ovFlags  out  4  flags from the last executed command.
- oHecho  out  1  one-cycle completion pulse.

Behaviour:
- Clocking/reset: one clock (iClk); reset is synchronous and active-high (iReset).
- Reset values: state IDLE; all bank entries 0; ovFlags 0; ovAlu* 0; oHecho 0.
- oListo is 0 while iReset is high and 1 in the first cycle after release.
- FSM states: IDLE and EXEC.
- IDLE: oListo=1. At an edge with iValido & oListo:
  - ovAluInstruccion <= ivInstruccion.
  - ovAluA <= bank[ivSelA].
  - ovAluB <= bank[ivSelB].
  - Latch ivSelDestino.
  - Go to EXEC.
- EXEC: oListo=0; ALU inputs are stable for the whole cycle. At the end of EXEC:
  - bank[dest] <= ivAluResultado.
  - ovFlags <= ivAluFlags.
  - oHecho <= 1 for exactly one cycle.
  - Return to IDLE.
- Latency and throughput:
  - Command accepted at edge N; ALU outputs sampled at edge N+1.
  - Result visible on ovDatoLectura and ovFlags at N+1, the same cycle oHecho=1; oListo=1 again in that cycle.
  - Maximum throughput is one command per 2 cycles.
- Operand capture: operands are read at acceptance. Loads or writebacks to source registers after acceptance do not affect the command in flight.
- Back-to-back dependency: a command accepted in the oHecho cycle reads the just-written value.
- Commands carry no bypass beyond that.
- Result width: ivAluResultado is DATA_W; it is stored as-is with no extension.
- Loads: iCargar is honoured in any state: bank[ivSelCarga] <= ivDatoCarga at the edge. Loads do not touch flags or oHecho.
- Load/writeback collision (same register, same edge): writeback wins, the load is dropped. Different registers both update.
- iValido while oListo=0: ignored. The sender holds the command until it sees oListo.
- Reset during EXEC aborts the command: no writeback, no oHecho, all reset values apply.

Optional Feature:
ALU_SECUENCIADOR_COND_EN
- Enabled:
  - Adds input ivCondicion[1:0], captured at acceptance.
  - Codes: 00 always; 01 only if ovFlags[0]=1; 10 only if ovFlags[1]=1; 11 only if ovFlags[0]=0.
  - The condition is evaluated against ovFlags at acceptance.
  - A failed command still takes EXEC and pulses oHecho; bank and ovFlags are unchanged.
  - Adds output oOmitido, pulsed together with oHecho.
- Disabled: ivCondicion and oOmitido do not exist, and every command executes.

Test Plan:
- Assert iReset 2 cycles, release -> all readbacks 0, ovFlags=0, oHecho=0, oListo=1 first cycle after release.
- Load R0=4'b0001, R1=4'b0001; issue op 4'b0000, A=R0, B=R1, dest R2 -> next cycle ovAluA=1, ovAluB=1; following cycle oHecho=1 and R2 = the ALU model's result (4'b0010 for add), ovFlags = model flags.
- Hold iValido high with cmd1 (dest R2) then cmd2 (A=R2) -> acceptances exactly 2 cycles apart; cmd2 drives ovAluA with cmd1's result.
- iCargar to R2 with 4'hF on the same edge as writeback of 4'h2 to R2 -> R2=4'h2; load to R3 on the same edge -> R3=4'hF.
- Assert iReset during EXEC -> no oHecho, destination register stays 0, oListo=1 after release.
- With ALU_SECUENCIADOR_COND_EN, ovFlags[0]=0, ivCondicion=01 -> oHecho=1, oOmitido=1, destination and ovFlags unchanged.
